// File: rtl/hazard_pkg.sv
// hazard_pkg: shared forwarding-select codes, FSM states and bubble constant
// Config macro WB_BYPASS_EN: enables the retained-WB match (select FWD_WBRET).
package hazard_pkg;
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_WBRET = 2'b11;
  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_e;
  // {reg_write, mem_read} of an empty pipeline slot
  localparam logic [1:0] CTL_BUBBLE = 2'b00;
`ifdef WB_BYPASS_EN
  localparam logic WB_BYP = 1'b1;
`else
  localparam logic WB_BYP = 1'b0;
`endif
endpackage

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// fwd_select: per-operand forwarding select, nearest in-flight writer wins
// Ports: src/en = source index and read enable; {ex,mem,wb}_{rd,wr} = shadow dest and write flag; sel = select.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0] src,
  input  logic         en,
  input  logic [W-1:0] ex_rd,
  input  logic         ex_wr,
  input  logic [W-1:0] mem_rd,
  input  logic         mem_wr,
  input  logic [W-1:0] wb_rd,
  input  logic         wb_wr,
  output logic [1:0]   sel
);
  // src==0 short-circuits, so x0 never forwards
  always_comb
    sel = (!en || src == '0)           ? FWD_RF    :
          (ex_wr && ex_rd == src)      ? FWD_EXMEM :
          (mem_wr && mem_rd == src)    ? FWD_MEMWB :
          (WB_BYP && wb_wr && wb_rd == src) ? FWD_WBRET : FWD_RF;
endmodule

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: EX operand forwarding selects and load-use stall control
// Ports: clk, reset (sync, active-high); id_* = instruction in ID; flush = branch redirect;
//   stall = freeze PC and IF/ID; ex_fwd_a/ex_fwd_b/ex_alusrc = registered EX operand controls.
// Config macro WB_BYPASS_EN (see hazard_pkg) adds select 11 for the retiring WB write.
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_STALL = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs2,
  input  logic                  id_alusrc,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic                  stall,
  output logic [1:0]            ex_fwd_a,
  output logic [1:0]            ex_fwd_b,
  output logic                  ex_alusrc
);
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d, mem_rd_q, wb_rd_q;
  logic ex_wr_q, ex_ld_q, ex_wr_d, ex_ld_d, mem_wr_q, wb_wr_q;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d, sel_a, sel_b, cnt_q, cnt_d;
  logic alusrc_q, alusrc_d, load_use, bubble;
  state_e state_q, state_d;
  fwd_select #(.W(REG_ADDR_W)) u_sel_a (
    .src(id_rs1), .en(1'b1), .ex_rd(ex_rd_q), .ex_wr(ex_wr_q), .mem_rd(mem_rd_q),
    .mem_wr(mem_wr_q), .wb_rd(wb_rd_q), .wb_wr(wb_wr_q), .sel(sel_a)
  );
  fwd_select #(.W(REG_ADDR_W)) u_sel_b (
    .src(id_rs2), .en(id_use_rs2), .ex_rd(ex_rd_q), .ex_wr(ex_wr_q), .mem_rd(mem_rd_q),
    .mem_wr(mem_wr_q), .wb_rd(wb_rd_q), .wb_wr(wb_wr_q), .sel(sel_b)
  );
  always_comb begin
    load_use = id_valid && ex_ld_q && ex_rd_q != '0 &&
               (ex_rd_q == id_rs1 || (id_use_rs2 && ex_rd_q == id_rs2));
    stall    = !flush && (state_q == HOLD || load_use);
    bubble   = stall || flush || !id_valid;
    state_d  = flush ? RUN :
               state_q == HOLD ? (cnt_q <= 2'd1 ? RUN : HOLD) :
               (load_use && LOAD_STALL > 1) ? HOLD : RUN;
    cnt_d    = flush ? 2'd0 :
               state_q == HOLD ? cnt_q - 2'd1 :
               load_use ? 2'(LOAD_STALL - 1) : 2'd0;
    ex_rd_d  = bubble ? '0 : id_rd;
    {ex_wr_d, ex_ld_d} = bubble ? CTL_BUBBLE : {id_reg_write, id_mem_read};
    fwd_a_d  = bubble ? FWD_RF : sel_a;
    fwd_b_d  = bubble ? FWD_RF : sel_b;
    alusrc_d = !bubble && id_alusrc;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rd_q  <= '0;
      mem_rd_q <= '0;
      wb_rd_q  <= '0;
      {ex_wr_q, ex_ld_q} <= CTL_BUBBLE;
      mem_wr_q <= 1'b0;
      wb_wr_q  <= 1'b0;
      fwd_a_q  <= FWD_RF;
      fwd_b_q  <= FWD_RF;
      alusrc_q <= 1'b0;
      state_q  <= RUN;
      cnt_q    <= 2'd0;
    end else begin
      ex_rd_q  <= ex_rd_d;
      mem_rd_q <= ex_rd_q;
      wb_rd_q  <= mem_rd_q;
      ex_wr_q  <= ex_wr_d;
      ex_ld_q  <= ex_ld_d;
      mem_wr_q <= ex_wr_q;
      wb_wr_q  <= mem_wr_q;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
      alusrc_q <= alusrc_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
  end
  assign ex_fwd_a  = fwd_a_q;
  assign ex_fwd_b  = fwd_b_q;
  assign ex_alusrc = alusrc_q;
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl: directed and random checks against a pipeline-history model
module tb_hazard_forward_ctrl;
`ifdef WB_BYPASS_EN
  localparam int LS = 2;
  localparam int DEPTH = 3;
`else
  localparam int LS = 1;
  localparam int DEPTH = 2;
`endif
  typedef struct {logic [4:0] rd; logic wr; logic ld;} ent_t;
  logic clk = 0, reset = 1, id_valid = 0, id_use_rs2 = 0, id_alusrc = 0;
  logic id_reg_write = 0, id_mem_read = 0, flush = 0, stall, ex_alusrc;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic [1:0] ex_fwd_a, ex_fwd_b;
  int nchk = 0, npass = 0, hold_left = 0;
  ent_t pipe [3];
  logic s;
  hazard_forward_ctrl #(.REG_ADDR_W(5), .LOAD_STALL(LS)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs2(id_use_rs2), .id_alusrc(id_alusrc), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .flush(flush), .stall(stall), .ex_fwd_a(ex_fwd_a),
    .ex_fwd_b(ex_fwd_b), .ex_alusrc(ex_alusrc)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask
  // select = 1 + distance (0=EX,1=MEM,2=WB) of the youngest in-flight writer of src
  function automatic logic [1:0] model_sel(input logic [4:0] src, input logic en);
    if (!en || src == 0) return 2'd0;
    for (int k = 0; k < DEPTH; k++)
      if (pipe[k].wr && pipe[k].rd == src) return 2'(k + 1);
    return 2'd0;
  endfunction
  task automatic clear_model();
    for (int k = 0; k < 3; k++) pipe[k] = '{5'd0, 1'b0, 1'b0};
    hold_left = 0;
  endtask
  task automatic do_reset();
    reset = 1; id_valid = 0; flush = 0;
    @(posedge clk); #1;
    reset = 0;
    clear_model();
    check("rst_fwd_a", ex_fwd_a, 0);
    check("rst_fwd_b", ex_fwd_b, 0);
    check("rst_alusrc", ex_alusrc, 0);
    #1 check("rst_stall", stall, 0);
  endtask
  task automatic step(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic u2,
                      input logic as, input logic [4:0] rd, input logic wr, input logic ld,
                      input logic fl, output logic st);
    logic hz, es, bub;
    logic [1:0] ea, eb;
    ent_t n;
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use_rs2 = u2; id_alusrc = as;
    id_rd = rd; id_reg_write = wr; id_mem_read = ld; flush = fl;
    #1;
    hz = v && pipe[0].ld && pipe[0].rd != 0 && (pipe[0].rd == r1 || (u2 && pipe[0].rd == r2));
    es = !fl && (hold_left > 0 || hz);
    st = stall;
    check("stall", stall, es);
    bub = es || fl || !v;
    ea = bub ? 2'd0 : model_sel(r1, 1'b1);
    eb = bub ? 2'd0 : model_sel(r2, u2);
    n = bub ? '{5'd0, 1'b0, 1'b0} : '{rd, wr, ld};
    @(posedge clk);
    pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = n;
    hold_left = fl ? 0 : hold_left > 0 ? hold_left - 1 : hz ? LS - 1 : 0;
    #1;
    check("fwd_a", ex_fwd_a, ea);
    check("fwd_b", ex_fwd_b, eb);
    check("alusrc", ex_alusrc, bub ? 1'b0 : as);
  endtask
  task automatic nop();
    logic d;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, d);
  endtask
  initial begin
    #1 do_reset();
    // back-to-back EX/MEM forward
    step(1, 1, 2, 1, 0, 3, 1, 0, 0, s);
    step(1, 3, 5, 1, 0, 4, 1, 0, 0, s);
    check("t1_fa", ex_fwd_a, 1);
    check("t1_stall", s, 0);
    // one-gap MEM/WB forward, and immediate operand ignores rs2
    step(1, 1, 2, 1, 0, 3, 1, 0, 0, s); nop();
    step(1, 3, 3, 1, 0, 6, 1, 0, 0, s);
    check("t2_fa", ex_fwd_a, 2);
    check("t2_fb", ex_fwd_b, 2);
    step(1, 1, 2, 1, 0, 3, 1, 0, 0, s); nop();
    step(1, 3, 3, 0, 1, 6, 1, 0, 0, s);
    check("t2_fb_imm", ex_fwd_b, 0);
    check("t2_alusrc", ex_alusrc, 1);
    // load-use
    do_reset();
    step(1, 1, 2, 0, 1, 7, 1, 1, 0, s);
    step(1, 7, 1, 1, 0, 8, 1, 0, 0, s);
    check("t3_stall", s, 1);
    for (int i = 1; i < LS; i++) step(1, 7, 1, 1, 0, 8, 1, 0, 0, s);
    step(1, 7, 1, 1, 0, 8, 1, 0, 0, s);
    check("t3_stall_done", s, 0);
    check("t3_fa", ex_fwd_a, LS == 1 ? 2 : 3);
    // x0 never forwards nor stalls
    step(1, 1, 2, 0, 0, 0, 1, 0, 0, s);
    step(1, 0, 0, 1, 0, 5, 1, 0, 0, s);
    check("t4_fa", ex_fwd_a, 0);
    check("t4_fb", ex_fwd_b, 0);
    step(1, 1, 2, 0, 1, 0, 1, 1, 0, s);
    step(1, 0, 0, 1, 0, 5, 1, 0, 0, s);
    check("t4_stall", s, 0);
    // flush beats load-use stall
    step(1, 1, 2, 0, 1, 7, 1, 1, 0, s);
    step(1, 7, 7, 1, 1, 8, 1, 0, 1, s);
    check("t5_flush_stall", s, 0);
    check("t5_flush_fa", ex_fwd_a, 0);
    check("t5_flush_as", ex_alusrc, 0);
    // reset in the middle of a load-use hold
    step(1, 1, 2, 0, 1, 7, 1, 1, 0, s);
    step(1, 7, 1, 1, 0, 8, 1, 0, 0, s);
    do_reset();
    // random traffic with small register indices so hazards are frequent
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      else step($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, s);
    end
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
